// File: rtl/lsu_port_arbiter.sv
// Shares one single-port data memory between the pipeline MEM stage (port A, priority)
// and the debug/boot loader (port B), with bounded B starvation and response timeout.
module lsu_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned CNT_W        = 5
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_a_req,
  input  logic        i_a_wren,
  input  logic [31:0] i_a_addr,
  input  logic [31:0] i_a_wdata,
  input  logic [2:0]  i_a_size,
  output logic [31:0] o_a_rdata,
  output logic        o_a_done,
  output logic        o_a_err,
  output logic        o_a_stall,
  input  logic        i_b_req,
  input  logic        i_b_wren,
  input  logic [31:0] i_b_addr,
  input  logic [31:0] i_b_wdata,
  input  logic [2:0]  i_b_size,
  output logic [31:0] o_b_rdata,
  output logic        o_b_done,
  output logic        o_b_err,
  output logic        o_m_req,
  output logic        o_m_wren,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_wdata,
  output logic [2:0]  o_m_size,
  input  logic        i_m_ready,
  input  logic        i_m_rvalid,
  input  logic [31:0] i_m_rdata
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] TMO_MAX    = CNT_W'(TIMEOUT);
  localparam logic [31:0]      ERR_DATA   = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  state_e            state_q;
  logic [SW-1:0]     starve_cnt_q;
  logic [CNT_W-1:0]  tmo_cnt_q;
  logic              owner_b_q;
  logic              m_req_q;
  logic              m_wren_q;
  logic [31:0]       m_addr_q;
  logic [31:0]       m_wdata_q;
  logic [2:0]        m_size_q;
  logic [31:0]       a_rdata_q;
  logic [31:0]       b_rdata_q;
  logic              a_done_q;
  logic              b_done_q;
  logic              a_err_q;
  logic              b_err_q;

  logic              grant_b_d;
  logic [SW-1:0]     starve_inc_d;
  logic [CNT_W-1:0]  tmo_cnt_d;
  logic              finish_d;
  logic              capture_d;
  logic              err_d;
  logic [31:0]       rsp_data_d;

  // Arbitration decision and memory-response classification for the current cycle.
  always_comb begin
    grant_b_d    = 1'b0;
    starve_inc_d = starve_cnt_q;
    tmo_cnt_d    = tmo_cnt_q + 1'b1;
    finish_d     = 1'b0;
    capture_d    = 1'b0;
    err_d        = 1'b0;
    rsp_data_d   = i_m_rdata;

    if (i_b_req && (!i_a_req || (starve_cnt_q == STARVE_MAX))) begin
      grant_b_d = 1'b1;
    end else begin
      grant_b_d = 1'b0;
    end

    if (starve_cnt_q == STARVE_MAX) begin
      starve_inc_d = starve_cnt_q;
    end else begin
      starve_inc_d = starve_cnt_q + 1'b1;
    end

    case (state_q)
      S_ISSUE: begin
        // A read whose data arrives in the accept cycle skips WAIT_RSP entirely.
        if (i_m_ready && (m_wren_q || i_m_rvalid)) begin
          finish_d  = 1'b1;
          capture_d = !m_wren_q;
        end else begin
          finish_d  = 1'b0;
        end
      end
      S_WAIT_RSP: begin
        if (i_m_rvalid) begin
          finish_d  = 1'b1;
          capture_d = 1'b1;
        end else if (tmo_cnt_d >= TMO_MAX) begin
          finish_d   = 1'b1;
          capture_d  = 1'b1;
          err_d      = 1'b1;
          rsp_data_d = ERR_DATA;
        end else begin
          finish_d  = 1'b0;
        end
      end
      default: begin
        finish_d = 1'b0;
      end
    endcase
  end

  // Access sequencer: arbitration, latched request, response capture and done pulses.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q      <= S_IDLE;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      owner_b_q    <= 1'b0;
      m_req_q      <= 1'b0;
      m_wren_q     <= 1'b0;
      m_addr_q     <= 32'h0000_0000;
      m_wdata_q    <= 32'h0000_0000;
      m_size_q     <= 3'd0;
      a_rdata_q    <= 32'h0000_0000;
      b_rdata_q    <= 32'h0000_0000;
      a_done_q     <= 1'b0;
      b_done_q     <= 1'b0;
      a_err_q      <= 1'b0;
      b_err_q      <= 1'b0;
    end else begin
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      a_err_q  <= 1'b0;
      b_err_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (i_a_req || i_b_req) begin
            owner_b_q <= grant_b_d;
            m_req_q   <= 1'b1;
            state_q   <= S_ISSUE;
            if (grant_b_d) begin
              m_wren_q     <= i_b_wren;
              m_addr_q     <= i_b_addr;
              m_wdata_q    <= i_b_wdata;
              m_size_q     <= i_b_size;
              starve_cnt_q <= '0;
            end else begin
              m_wren_q     <= i_a_wren;
              m_addr_q     <= i_a_addr;
              m_wdata_q    <= i_a_wdata;
              m_size_q     <= i_a_size;
              starve_cnt_q <= i_b_req ? starve_inc_d : '0;
            end
          end else begin
            starve_cnt_q <= '0;
          end
        end
        S_ISSUE: begin
          if (i_m_ready) begin
            m_req_q <= 1'b0;
            if (!finish_d) begin
              // Counter tracks cycles since accept, so the abort lands TIMEOUT cycles later.
              tmo_cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
              state_q   <= S_WAIT_RSP;
            end else begin
              tmo_cnt_q <= tmo_cnt_q;
            end
          end else begin
            m_req_q <= 1'b1;
          end
        end
        S_WAIT_RSP: begin
          tmo_cnt_q <= tmo_cnt_d;
        end
        S_DONE: begin
          tmo_cnt_q <= '0;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      if (finish_d) begin
        state_q  <= S_DONE;
        a_done_q <= !owner_b_q;
        b_done_q <= owner_b_q;
        a_err_q  <= !owner_b_q && err_d;
        b_err_q  <= owner_b_q && err_d;
        if (capture_d && owner_b_q) begin
          b_rdata_q <= rsp_data_d;
        end else if (capture_d) begin
          a_rdata_q <= rsp_data_d;
        end
      end
    end
  end

  assign o_a_stall = i_a_req & ~a_done_q;
  assign o_a_rdata = a_rdata_q;
  assign o_a_done  = a_done_q;
  assign o_a_err   = a_err_q;
  assign o_b_rdata = b_rdata_q;
  assign o_b_done  = b_done_q;
  assign o_b_err   = b_err_q;
  assign o_m_req   = m_req_q;
  assign o_m_wren  = m_wren_q;
  assign o_m_addr  = m_addr_q;
  assign o_m_wdata = m_wdata_q;
  assign o_m_size  = m_size_q;

endmodule
